apb_poll_master: RTL
====================

// Module: apb_poll_master
// PURPOSE
//  APB3 initiator that turns single-entry commands (write, read, poll-until-clear) into
//  SETUP/ACCESS bus transfers toward APB register blocks such as DDS_cont.
//  Sits between a PS-side or sequencer command source and the peripheral APB port.
//  Replaces bench-only write/read/poll tasks with synthesizable RTL.
//  Adds a pready timeout and a poll iteration limit.
// PARAMETERS
//  ADDR_W    32    paddr / cmd_addr width
//  DATA_W    32    pwdata / prdata / cmd_wdata / rsp_rdata width
//  TIMEOUT   255   max ACCESS cycles waiting for pready before abort (8-bit counter)
//  POLL_MAX  1023  max poll read iterations before abort (10-bit counter)
// PORTS
//  aclk       in   1       bus clock
//  rstn       in   1       reset, asynchronous, active-high
//  cmd_valid  in   1       command request
//  cmd_ready  out  1       command accepted when valid&ready
//  cmd_op     in   2       00 write, 01 read, 10 poll-until-zero, 11 illegal
//  cmd_addr   in   ADDR_W  target address
//  cmd_wdata  in   DATA_W  write data (op 00) / poll mask (op 10)
//  rsp_valid  out  1       one-cycle completion pulse
//  rsp_rdata  out  DATA_W  last sampled prdata (0 for writes)
//  rsp_err    out  2       00 ok, 01 pslverr/illegal, 10 timeout, 11 poll limit
//  paddr      out  ADDR_W  APB address
//  psel       out  1       APB select
//  penable    out  1       APB enable
//  pwrite     out  1       APB direction
//  pwdata     out  DATA_W  APB write data
//  prdata     in   DATA_W  APB read data
//  pready     in   1       APB ready
//  pslverr    in   1       APB slave error
// BEHAVIOUR
//  Reset: every output is 0 and state is IDLE. Reset is async: mid-transfer, psel/penable
//   drop immediately and no rsp is produced.
//  States: IDLE, SETUP, ACCESS, GAP, RESP.
//  IDLE: cmd_ready=1; all APB outputs 0. On accept, latch op/addr/wdata.
//   op 11 goes to RESP with err=01 and no bus activity. Otherwise go to SETUP.
//  SETUP (1 cycle): psel=1, penable=0, paddr=addr, pwrite=(op==00),
//   pwdata=wdata for writes, else 0. Next state is ACCESS.
//  ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held stable.
//   - Timeout counter clears on entry to SETUP and increments each ACCESS cycle without
//     pready.
//   - pready=1: sample prdata into rsp_rdata (reads/polls only), then deassert psel/penable.
//   - pslverr & pready gives err=01, then RESP; a poll aborts on pslverr.
//   - Write/read without error goes to RESP.
//   - Poll: if (prdata & mask)==0 go to RESP, err=00. Otherwise poll_cnt++.
//     If poll_cnt==POLL_MAX go to RESP with err=11, else go to GAP.
//   - If the counter reaches TIMEOUT with pready still 0, drop psel/penable and go to RESP
//     with err=10.
//  GAP (1 cycle): psel=0; then SETUP with the same address (re-poll).
//  RESP (1 cycle): rsp_valid=1 with rsp_rdata/rsp_err stable; next state is IDLE.
//   rsp_rdata/rsp_err hold until the next accept.
//  Latency, zero-wait slave: accept edge N, SETUP N+1, ACCESS N+2, rsp_valid at N+3.
//   Each wait state adds 1 cycle; each extra poll iteration adds 3 cycles.
//  poll_cnt clears on accept. Mask 0 makes a poll finish after one read.
//  pslverr is ignored when pready=0.
// TESTING
//  1 Write 0x43c30008 / 0x04120514, zero-wait slave -> psel at N+1, penable at N+2,
//    pwdata=0x04120514, rsp_valid at N+3, err=00.
//  2 Read 0x43c3000c, slave gives 3 wait states then prdata=0x55 -> rsp_rdata=0x55,
//    rsp_valid at N+6, paddr stable throughout.
//  3 Poll 0x43c30004 with mask 0x1; slave returns 1,1,1,0 -> 4 reads with psel low
//    1 cycle between each; rsp err=00, rdata=0.
//  4 Slave never asserts pready -> psel drops after 255 ACCESS cycles, rsp err=10;
//    with pslverr+pready instead -> err=01.
//  5 Poll with slave stuck at 1 -> exactly 1023 reads, err=11. op=11 -> rsp_valid at N+1,
//    err=01, psel never high.
//  6 Assert rstn during ACCESS -> psel/penable/cmd_ready/rsp_valid are 0 the same time
//    step. After release, the next write completes normally.

Source files
------------

// File: rtl/apb_poll_master_if.sv
// Command/response handshake plus APB3 bus bundle for apb_poll_master.
// master: the initiator's view. slave: the command source / peripheral side.
interface apb_poll_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  // command side
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  // response side
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_err;
  // APB3 bus
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/apb_poll_master.sv
// APB3 initiator: executes one write / read / poll-until-clear command at a time,
// with a pready timeout and a bounded number of poll iterations.
module apb_poll_master #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 255,
  parameter int POLL_MAX = 1023
) (
  input  logic aclk,
  input  logic rstn,
  apb_poll_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, GAP, RESP} state_t;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;
  localparam logic [1:0] E_OK    = 2'b00;
  localparam logic [1:0] E_SLV   = 2'b01;
  localparam logic [1:0] E_TMO   = 2'b10;
  localparam logic [1:0] E_PLIM  = 2'b11;
  localparam logic [7:0] TMO     = 8'(TIMEOUT);
  localparam logic [9:0] PMAX    = 10'(POLL_MAX);

  state_t            state, state_nxt;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;          // write data, or poll mask
  logic [7:0]        tcnt_q, tcnt_nxt; // ACCESS cycles without pready
  logic [9:0]        pcnt_q, pcnt_nxt; // poll reads that came back non-zero
  logic [DATA_W-1:0] rdata_q, rdata_nxt;
  logic [1:0]        err_q, err_nxt;
  logic              accept;
  logic              sel, wr;

  // Bus outputs decode straight from state so an async reset drops them at once.
  assign sel           = (state == SETUP) || (state == ACCESS);
  assign wr            = (op_q == OP_WR);
  assign bus.psel      = sel;
  assign bus.penable   = (state == ACCESS);
  assign bus.paddr     = sel ? addr_q : '0;
  assign bus.pwrite    = sel && wr;
  assign bus.pwdata    = (sel && wr) ? wdata_q : '0;
  assign bus.cmd_ready = (state == IDLE) && !rstn;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Next-state, counters and response capture.
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt_q;
    pcnt_nxt  = pcnt_q;
    rdata_nxt = rdata_q;
    err_nxt   = err_q;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept    = 1'b1;
          tcnt_nxt  = '0;
          pcnt_nxt  = '0;
          rdata_nxt = '0;
          if (bus.cmd_op == OP_ILL) begin
            err_nxt   = E_SLV;
            state_nxt = RESP;
          end else begin
            err_nxt   = E_OK;
            state_nxt = SETUP;
          end
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (bus.pready) begin
          if (!wr) rdata_nxt = bus.prdata;
          if (bus.pslverr) begin
            err_nxt   = E_SLV;
            state_nxt = RESP;
          end else if (op_q != OP_POLL) begin
            state_nxt = RESP;
          end else if ((bus.prdata & wdata_q) == '0) begin
            state_nxt = RESP;
          end else begin
            pcnt_nxt = pcnt_q + 10'd1;
            if (pcnt_q + 10'd1 == PMAX) begin
              err_nxt   = E_PLIM;
              state_nxt = RESP;
            end else begin
              state_nxt = GAP;
            end
          end
        end else if (tcnt_q + 8'd1 == TMO) begin
          // pslverr without pready is meaningless and not looked at here
          err_nxt   = E_TMO;
          state_nxt = RESP;
        end else begin
          tcnt_nxt = tcnt_q + 8'd1;
        end
      end
      GAP: begin
        tcnt_nxt  = '0;
        state_nxt = SETUP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; command fields latched on accept.
  always_ff @(posedge aclk or posedge rstn) begin
    if (rstn) begin
      state   <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      tcnt_q  <= '0;
      pcnt_q  <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state   <= state_nxt;
      tcnt_q  <= tcnt_nxt;
      pcnt_q  <= pcnt_nxt;
      rdata_q <= rdata_nxt;
      err_q   <= err_nxt;
      if (accept) begin
        op_q    <= bus.cmd_op;
        addr_q  <= bus.cmd_addr;
        wdata_q <= bus.cmd_wdata;
      end
    end
  end
endmodule
